// File: rtl/mul_pkg.sv
// Shared encodings for the sequential radix-4 Booth multiplier.
package mul_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Booth digit selection. Bit 2 flags a negated addend; bits [1:0] give the magnitude.
  typedef enum logic [2:0] {
    ZERO     = 3'b000,
    PLUS_M   = 3'b001,
    PLUS_2M  = 3'b010,
    MINUS_M  = 3'b101,
    MINUS_2M = 3'b110
  } booth_digit_e;

  // Map the multiplier triplet {q[1], q[0], q[-1]} to its radix-4 Booth digit.
  function automatic booth_digit_e booth_decode(input logic [2:0] trip);
    booth_digit_e d;
    unique case (trip)
      3'b000, 3'b111: d = ZERO;
      3'b001, 3'b010: d = PLUS_M;
      3'b011:         d = PLUS_2M;
      3'b100:         d = MINUS_2M;
      3'b101, 3'b110: d = MINUS_M;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seq_booth_mul_if.sv
// Start/busy/done handshake and operand/product bus of the Booth multiplier.
interface seq_booth_mul_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] zlow;
  logic [WIDTH-1:0] zhigh;

  // Requester side (control unit).
  modport master (
    output start, signed_mode, in1, in2,
    input  busy, done, zlow, zhigh
  );

  // Multiplier side.
  modport slave (
    input  start, signed_mode, in1, in2,
    output busy, done, zlow, zhigh
  );
endinterface

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth encoder: selects 0, +-M or +-2M at WIDTH+3 bits from a multiplier triplet.
module booth_r4_enc
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2:0]       triplet,
  input  logic [WIDTH+1:0] m,
  output logic [WIDTH+2:0] addend_c
);

  localparam int unsigned ACC_W = WIDTH + 3;

  booth_digit_e     digit;
  logic [ACC_W-1:0] m1;
  logic [ACC_W-1:0] m2;

  // Decode the digit and pick the matching signed multiple of M.
  always_comb begin
    digit    = booth_decode(triplet);
    m1       = {m[WIDTH+1], m};
    m2       = {m, 1'b0};
    addend_c = '0;
    unique case (digit)
      PLUS_M:   addend_c = m1;
      PLUS_2M:  addend_c = m2;
      MINUS_M:  addend_c = ACC_W'(-m1);
      MINUS_2M: addend_c = ACC_W'(-m2);
      default:  addend_c = '0;
    endcase
  end

endmodule

// File: rtl/seq_booth_mul.sv
// Multi-cycle radix-4 Booth multiplier: one digit per clock, signed or unsigned operands.
module seq_booth_mul
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic           clk,
  input logic           clr,
  seq_booth_mul_if.slave bus
);

  localparam int unsigned EXT_W = WIDTH + 2;
  localparam int unsigned ACC_W = WIDTH + 3;
  localparam int unsigned SH_W  = ACC_W + EXT_W + 1;
  localparam int unsigned ITER  = (WIDTH + 2) / 2;
  localparam int unsigned CNT_W = $clog2(ITER + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [EXT_W-1:0] m_q, m_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [EXT_W-1:0] q_q, q_d;
  logic             qm1_q, qm1_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] zlow_q, zlow_d;
  logic [WIDTH-1:0] zhigh_q, zhigh_d;

  logic [ACC_W-1:0] addend_c;
  logic [ACC_W-1:0] sum_c;
  logic [SH_W-1:0]  sh_c;

  booth_r4_enc #(
    .WIDTH (WIDTH)
  ) u_enc (
    .triplet  ({q_q[1:0], qm1_q}),
    .m        (m_q),
    .addend_c (addend_c)
  );

  // State, datapath and output registers; clr clears everything immediately.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      zlow_q  <= '0;
      zhigh_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      zlow_q  <= zlow_d;
      zhigh_q <= zhigh_d;
    end
  end

  // Next-state, Booth step and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    zlow_d  = zlow_q;
    zhigh_d = zhigh_q;

    // Add the selected multiple, then arithmetic shift {acc, q, q[-1]} right by one digit.
    sum_c = acc_q + addend_c;
    sh_c  = SH_W'($signed({sum_c, q_q, qm1_q}) >>> 2);

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          m_d     = bus.signed_mode ? {{2{bus.in1[WIDTH-1]}}, bus.in1} : {2'b00, bus.in1};
          q_d     = bus.signed_mode ? {{2{bus.in2[WIDTH-1]}}, bus.in2} : {2'b00, bus.in2};
          acc_d   = '0;
          qm1_d   = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy_d = 1'b1;
        acc_d  = sh_c[SH_W-1 -: ACC_W];
        q_d    = sh_c[EXT_W:1];
        qm1_d  = sh_c[0];
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITER - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b1;
        done_d  = 1'b1;
        zlow_d  = q_q[WIDTH-1:0];
        zhigh_d = {acc_q[WIDTH-3:0], q_q[EXT_W-1:WIDTH]};
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.zlow  = zlow_q;
  assign bus.zhigh = zhigh_q;

endmodule
